// File: rtl/logic_unit_bist.sv
// Built-in self-test controller for the 32-bit logical unit: drives LFSR operand
// vectors with all four opcodes, checks results against a golden model, and builds a MISR signature.
module logic_unit_bist #(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED_A      = 32'h1234_5678,
  parameter logic [31:0] SEED_B      = 32'h8765_4321
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] dut_a,
  output logic [31:0] dut_b,
  output logic [1:0]  dut_op,
  input  logic [31:0] dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx,
  output logic [31:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  localparam logic [31:0] POLY       = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX   = 16'(4 * NUM_VECTORS - 1);
  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  state_t      state;
  logic [15:0] idx;
  logic        mismatch;

  always_comb begin
    mismatch = (dut_out != golden(dut_a, dut_b, dut_op));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= 16'h0;
      dut_a          <= 32'h0;
      dut_b          <= 32'h0;
      dut_op         <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'h0;
      first_fail_idx <= 16'hFFFF;
      signature      <= 32'h0;
    end else if (abort) begin
      // Partial err_count / first_fail_idx / signature are left visible.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_DRIVE;
            idx            <= 16'h0;
            dut_a          <= SEED_A_EFF;
            dut_b          <= SEED_B_EFF;
            dut_op         <= 2'b00;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'h0;
            first_fail_idx <= 16'hFFFF;
            signature      <= 32'h0;
          end
        end
        S_DRIVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          signature <= lfsr_step(signature) ^ dut_out;
          if (mismatch) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'h1;
            end
            if (first_fail_idx == 16'hFFFF) begin
              first_fail_idx <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            state  <= S_DRIVE;
            idx    <= idx + 16'h1;
            dut_op <= dut_op + 2'b01;
            // New operand pair only once all four opcodes have been applied.
            if (dut_op == 2'b11) begin
              dut_a <= lfsr_step(dut_a);
              dut_b <= lfsr_step(dut_b);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 16'h0);
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_bist.sv
// Self-checking bench for logic_unit_bist: a behavioural logical unit with selectable
// faults, a reference model feeding expected vectors/results into scoreboard queues.
module tb_logic_unit_bist;

  localparam int          NV   = 4;
  localparam int          NCHK = 4 * NV;
  localparam logic [31:0] SA   = 32'h1234_5678;
  localparam logic [31:0] SB   = 32'h8765_4321;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] dut_a, dut_b, dut_out, signature;
  logic [1:0]  dut_op;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;

  int fault_mode = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] err;
    logic [15:0] ffi;
    logic [31:0] sig;
  } res_t;

  res_t        res_q[$];
  logic [65:0] vec_q[$];

  always #5 clk = ~clk;

  logic_unit_bist #(.NUM_VECTORS(NV), .SEED_A(SA), .SEED_B(SB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_a(dut_a), .dut_b(dut_b), .dut_op(dut_op), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .signature(signature)
  );

  function automatic logic [31:0] step(input logic [31:0] x);
    return x[31] ? ({x[30:0], 1'b0} ^ 32'h8020_0003) : {x[30:0], 1'b0};
  endfunction

  // mode 0: correct, 1: out[0] stuck at 0, 2: ops 01 and 10 swapped
  function automatic logic [31:0] unit_fn(input int mode, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = (mode == 2) ? (a ^ b) : (a | b);
      2'd2:    r = (mode == 2) ? (a | b) : (a ^ b);
      default: r = ~(a | b);
    endcase
    if (mode == 1) r[0] = 1'b0;
    return r;
  endfunction

  always_comb dut_out = unit_fn(fault_mode, dut_a, dut_b, dut_op);

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".busy"}, 66'(busy), 66'(0));
    check({tag, ".done"}, 66'(done), 66'(0));
    check({tag, ".pass"}, 66'(pass), 66'(0));
    check({tag, ".err_count"}, 66'(err_count), 66'(0));
    check({tag, ".first_fail_idx"}, 66'(first_fail_idx), 66'(16'hFFFF));
    check({tag, ".signature"}, 66'(signature), 66'(0));
    check({tag, ".vector"}, {dut_a, dut_b, dut_op}, 66'(0));
  endtask

  // Expected vectors for a full run plus results after the first nchk checks.
  task automatic push_expect(input int mode, input int nchk);
    logic [31:0] a, b, gold, o;
    logic [1:0]  op;
    res_t        r;
    a = SA; b = SB;
    r.err = 16'h0; r.ffi = 16'hFFFF; r.sig = 32'h0;
    for (int i = 0; i < NCHK; i++) begin
      op = 2'(i % 4);
      vec_q.push_back({a, b, op});
      if (i < nchk) begin
        case (op)
          2'd0:    gold = a & b;
          2'd1:    gold = a | b;
          2'd2:    gold = a ^ b;
          default: gold = ~(a | b);
        endcase
        o = unit_fn(mode, a, b, op);
        if (o != gold) begin
          if (r.err != 16'hFFFF) r.err = r.err + 16'h1;
          if (r.ffi == 16'hFFFF) r.ffi = 16'(i);
        end
        r.sig = step(r.sig) ^ o;
      end
      if (op == 2'd3) begin
        a = step(a);
        b = step(b);
      end
    end
    res_q.push_back(r);
  endtask

  task automatic compare_results(input string tag);
    res_t r;
    r = res_q.pop_front();
    check({tag, ".err_count"}, 66'(err_count), 66'(r.err));
    check({tag, ".first_fail_idx"}, 66'(first_fail_idx), 66'(r.ffi));
    check({tag, ".signature"}, 66'(signature), 66'(r.sig));
    $display("run %s: err_count=%0d first_fail_idx=%h signature=%h", tag, err_count,
             first_fail_idx, signature);
  endtask

  task automatic run(input string tag, input int mode, input bit pulses,
                     input int abort_at, input int reset_at);
    logic [65:0] ev;
    fault_mode = mode;
    push_expect(mode, (abort_at >= 0) ? abort_at / 2 : NCHK);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy_after_start"}, 66'(busy), 66'(1));
    ev = vec_q.pop_front();
    check({tag, ".vec0"}, {dut_a, dut_b, dut_op}, ev);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (abort_at >= 0 && c == abort_at + 1) begin
        check({tag, ".busy_after_abort"}, 66'(busy), 66'(0));
        check({tag, ".done_after_abort"}, 66'(done), 66'(0));
        compare_results(tag);
        vec_q.delete();
        return;
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset({tag, ".midrun_reset"});
        vec_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (pulses && (c == 3 || c == 10)) start = 1'b1;
      if (c == abort_at) abort = 1'b1;
      if (c % 2 == 0 && c / 2 < NCHK) begin
        ev = vec_q.pop_front();
        check($sformatf("%s.vec%0d", tag, c / 2), {dut_a, dut_b, dut_op}, ev);
      end
      if (done) begin
        check({tag, ".cycles_to_done"}, 66'(c), 66'(8 * NV + 1));
        check({tag, ".busy_at_done"}, 66'(busy), 66'(0));
        check({tag, ".pass"}, 66'(pass), 66'(res_q[0].err == 16'h0));
        compare_results(tag);
        return;
      end
    end
    check({tag, ".timeout_waiting_done"}, 66'(done), 66'(1));
    vec_q.delete();
    res_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    run("clean", 0, 1'b0, -1, -1);
    run("stuck0", 1, 1'b0, -1, -1);
    run("swap", 2, 1'b0, -1, -1);
    run("restart_pulses", 0, 1'b1, -1, -1);
    run("abort9", 0, 1'b0, 9, -1);
    run("after_abort", 0, 1'b0, -1, -1);

    // abort and start together from IDLE: abort wins, done is cleared
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_start.busy", 66'(busy), 66'(0));
    check("abort_start.done", 66'(done), 66'(0));

    run("reset12", 0, 1'b0, -1, 12);
    run("after_reset", 0, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
